// File: rtl/preset_timer.sv
// preset_timer: single-clock mm:ss countdown timer with a preset register,
// auto-reload, wrap-around editing, pause/resume, a one-cycle expiry pulse
// and a blink output for the alarm display.
// No valid/ready handshakes here: every control input is a single-cycle
// pulse that is sampled on the rising edge where it is high.
module preset_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int MIN_MAX       = 59,
    parameter int MIN_W         = 6,
    parameter int BLINK_TICKS   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             inc_min,
    input  logic             inc_sec,
    input  logic             dir,
    input  logic             auto_reload,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic             running,
    output logic             expired,
    output logic             blink,
    output logic [1:0]       dbg_state
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [MIN_W-1:0] MIN_TOP    = MIN_W'(MIN_MAX);
    localparam logic [5:0]       SEC_TOP    = 6'd59;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [MIN_W-1:0] r_min, r_pmin, w_min_nx, w_pmin_nx;
    logic [5:0]       r_sec, r_psec, w_sec_nx, w_psec_nx;
    logic [PW-1:0]    r_presc, w_presc_nx;
    logic [BW-1:0]    r_bcnt, w_bcnt_nx;
    logic             r_blink, w_blink_nx;
    logic             r_expired, w_exp_nx;

    logic [MIN_W-1:0] w_edit_min, w_cnt_min;
    logic [5:0]       w_edit_sec, w_cnt_sec;
    logic             w_edit, w_preset_nz, w_edit_nz, w_cnt_zero, w_bcnt_wrap;

    // Field-local edit steps (wrap with explicit compares, no carry between
    // fields) and the one-second decrement with minute borrow.
    always_comb begin
        w_edit_min = r_min;
        w_edit_sec = r_sec;
        if (inc_min) begin
            if (dir) w_edit_min = (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);
            else     w_edit_min = (r_min == '0) ? MIN_TOP : r_min - MIN_W'(1);
        end
        if (inc_sec) begin
            if (dir) w_edit_sec = (r_sec == SEC_TOP) ? 6'd0 : r_sec + 6'd1;
            else     w_edit_sec = (r_sec == 6'd0) ? SEC_TOP : r_sec - 6'd1;
        end
        if (r_sec != 6'd0) begin
            w_cnt_sec = r_sec - 6'd1;
            w_cnt_min = r_min;
        end else begin
            w_cnt_sec = SEC_TOP;
            w_cnt_min = (r_min == '0) ? '0 : r_min - MIN_W'(1);
        end
    end

    assign w_edit      = inc_min | inc_sec;
    assign w_preset_nz = (r_pmin != '0) || (r_psec != 6'd0);
    assign w_edit_nz   = (w_edit_min != '0) || (w_edit_sec != 6'd0);
    assign w_cnt_zero  = (w_cnt_min == '0) && (w_cnt_sec == 6'd0);
    assign w_bcnt_wrap = (r_bcnt == BLINK_LAST);

    // Next-state and next-datapath logic; clear > start > stop > edit, and a
    // higher-priority pulse drops the lower ones even when it has no effect.
    always_comb begin
        w_state_nx = r_state;
        w_min_nx   = r_min;
        w_sec_nx   = r_sec;
        w_pmin_nx  = r_pmin;
        w_psec_nx  = r_psec;
        w_presc_nx = r_presc;
        w_bcnt_nx  = r_bcnt;
        w_blink_nx = r_blink;
        w_exp_nx   = 1'b0;
        if (clear) begin
            w_state_nx = S_IDLE;
            w_min_nx   = '0;
            w_sec_nx   = 6'd0;
            w_pmin_nx  = '0;
            w_psec_nx  = 6'd0;
            w_presc_nx = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!start && stop) begin
                        w_state_nx = S_ARMED;
                    end else if (en) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nx = '0;
                            if (w_cnt_zero) begin
                                w_exp_nx = 1'b1;
                                if (auto_reload) begin
                                    w_min_nx = r_pmin;
                                    w_sec_nx = r_psec;
                                end else begin
                                    w_min_nx   = '0;
                                    w_sec_nx   = 6'd0;
                                    w_state_nx = S_DONE;
                                    w_blink_nx = 1'b1;
                                    w_bcnt_nx  = '0;
                                end
                            end else begin
                                w_min_nx = w_cnt_min;
                                w_sec_nx = w_cnt_sec;
                            end
                        end else begin
                            w_presc_nx = r_presc + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (start && w_preset_nz) begin
                        w_state_nx = S_RUN;
                        w_min_nx   = r_pmin;
                        w_sec_nx   = r_psec;
                        w_presc_nx = '0;
                    end else if (!start && stop) begin
                        w_min_nx   = r_pmin;
                        w_sec_nx   = r_psec;
                        w_state_nx = w_preset_nz ? S_ARMED : S_IDLE;
                    end else if (!start && w_edit) begin
                        w_min_nx   = w_edit_min;
                        w_sec_nx   = w_edit_sec;
                        w_pmin_nx  = w_edit_min;
                        w_psec_nx  = w_edit_sec;
                        w_state_nx = w_edit_nz ? S_ARMED : S_IDLE;
                    end else begin
                        w_bcnt_nx  = w_bcnt_wrap ? '0 : r_bcnt + BW'(1);
                        w_blink_nx = w_bcnt_wrap ? ~r_blink : r_blink;
                    end
                end
                default: begin
                    if (start) begin
                        if (r_state == S_ARMED) w_state_nx = S_RUN;
                    end else if (!stop && w_edit) begin
                        w_min_nx   = w_edit_min;
                        w_sec_nx   = w_edit_sec;
                        w_pmin_nx  = w_edit_min;
                        w_psec_nx  = w_edit_sec;
                        w_state_nx = w_edit_nz ? S_ARMED : S_IDLE;
                    end
                end
            endcase
        end
        // The blink machinery only lives in DONE.
        if (w_state_nx != S_DONE) begin
            w_blink_nx = 1'b0;
            w_bcnt_nx  = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_min     <= '0;
            r_sec     <= 6'd0;
            r_pmin    <= '0;
            r_psec    <= 6'd0;
            r_presc   <= '0;
            r_bcnt    <= '0;
            r_blink   <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_min     <= w_min_nx;
            r_sec     <= w_sec_nx;
            r_pmin    <= w_pmin_nx;
            r_psec    <= w_psec_nx;
            r_presc   <= w_presc_nx;
            r_bcnt    <= w_bcnt_nx;
            r_blink   <= w_blink_nx;
            r_expired <= w_exp_nx;
        end
    end

    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign running   = (r_state == S_RUN);
    assign expired   = r_expired;
    assign blink     = r_blink;
    assign dbg_state = r_state;

endmodule
